// File: rtl/decode_pkg.sv
// Shared RV64I decode definitions: opcode/funct constants, mnemonic width,
// instruction formats and the immediate assembler.
package decode_pkg;

  localparam int MNEMONIC_CHARS = 12;
  localparam int MNEMONIC_BITS  = MNEMONIC_CHARS * 8;

  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;

  // ALU / shift funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // load / store size funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  // 64-bit immediate shifts use a 6-bit shamt, leaving a 6-bit funct field
  localparam logic [5:0] F6_BASE = 6'b000000;
  localparam logic [5:0] F6_ALT  = 6'b010000;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_t;

  function automatic logic [63:0] imm_gen(input fmt_t fmt, input logic [31:0] i);
    logic [63:0] imm;
    case (fmt)
      FMT_I:   imm = {{52{i[31]}}, i[31:20]};
      FMT_S:   imm = {{52{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   imm = {{32{i[31]}}, i[31:12], 12'h000};
      FMT_J:   imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = 64'h0;
    endcase
    return imm;
  endfunction

  function automatic logic has_rd(input fmt_t fmt);
    logic r;
    case (fmt)
      FMT_R, FMT_I, FMT_U, FMT_J: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Decode stage bus: fetch inputs, writeback port, dump request and the
// decoded operands handed to the next stage.
interface decode_if #(
  parameter int REGISTER_WIDTH         = 64,
  parameter int REGISTER_NUMBER_WIDTH  = 5,
  parameter int INSTRUCTION_NAME_WIDTH = 12
);
  logic [31:0]                       stage1_instruction_bits;
  logic [63:0]                       stage1_pc;
  logic [REGISTER_NUMBER_WIDTH:0]    stage3_dest_reg;
  logic [REGISTER_WIDTH-1:0]         stage3_alu_result;
  logic                              wr_en;
  logic                              display_regs;

  logic [REGISTER_WIDTH-1:0]         nstage2_valA;
  logic [REGISTER_WIDTH-1:0]         nstage2_valB;
  logic [63:0]                       nstage2_immediate;
  logic [63:0]                       nstage2_pc;
  logic [4:0]                        nstage2_dest;
  logic [INSTRUCTION_NAME_WIDTH*8:0] nstage2_op;

  modport master (
    output stage1_instruction_bits, stage1_pc, stage3_dest_reg,
           stage3_alu_result, wr_en, display_regs,
    input  nstage2_valA, nstage2_valB, nstage2_immediate, nstage2_pc,
           nstage2_dest, nstage2_op
  );

  modport slave (
    input  stage1_instruction_bits, stage1_pc, stage3_dest_reg,
           stage3_alu_result, wr_en, display_regs,
    output nstage2_valA, nstage2_valB, nstage2_immediate, nstage2_pc,
           nstage2_dest, nstage2_op
  );
endinterface

// File: rtl/decode_regfile.sv
// 32-entry register file: two combinational read ports with writeback bypass,
// one write port, x0 hardwired to zero. DECODE_DISPLAY_EN enables a register dump.
module decode_regfile #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic             wr_en,
  input  logic [4:0]       wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             display,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);

  logic [WIDTH-1:0] regs_r [32];

  // Register storage; reset takes priority over a coincident write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en && (wr_idx != 5'd0)) begin
      regs_r[wr_idx] <= wr_data;
    end
  end

  assign rd1 = (rs1 == 5'd0)                  ? '0      :
               (wr_en && (wr_idx == rs1))     ? wr_data : regs_r[rs1];
  assign rd2 = (rs2 == 5'd0)                  ? '0      :
               (wr_en && (wr_idx == rs2))     ? wr_data : regs_r[rs2];

`ifdef DECODE_DISPLAY_EN
  logic display_prev_r;

  // Previous display request, for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      display_prev_r <= 1'b0;
    end else begin
      display_prev_r <= display;
    end
  end

  // One dump per 0->1 transition of the request
  always_ff @(posedge clk) begin
    if (!reset && display && !display_prev_r) begin
      for (int i = 0; i < 32; i++) begin
        $display("x%0d = %016h", i, 64'(regs_r[i]));
      end
    end
  end
`else
  logic unused_display_s;
  assign unused_display_s = display;
`endif

endmodule

// File: rtl/decode.sv
// RV64I decode stage: mnemonic, destination and immediate extraction plus
// register operand fetch. Optional dump feature: DECODE_DISPLAY_EN.
module decode
  import decode_pkg::*;
#(
  parameter int REGISTER_WIDTH         = 64,
  parameter int REGISTER_NUMBER_WIDTH  = 5,
  parameter int INSTRUCTION_NAME_WIDTH = 12
) (
  input logic   clk,
  input logic   reset,
  decode_if.slave bus
);

  localparam int OP_W = INSTRUCTION_NAME_WIDTH * 8 + 1;

  logic [31:0]              instr_s;
  logic [6:0]               opcode_s;
  logic [2:0]               funct3_s;
  logic [6:0]               funct7_s;
  logic [5:0]               funct6_s;
  logic [MNEMONIC_BITS-1:0] mn_s;
  fmt_t                     fmt_s;
  logic                     unused_dest_hi_s;

  assign instr_s  = bus.stage1_instruction_bits;
  assign opcode_s = instr_s[6:0];
  assign funct3_s = instr_s[14:12];
  assign funct7_s = instr_s[31:25];
  assign funct6_s = instr_s[31:26];

  // Only the low five bits of the writeback index address the file
  assign unused_dest_hi_s = |bus.stage3_dest_reg[REGISTER_NUMBER_WIDTH:5];

  // Mnemonic and format selection; any unmatched field falls back to unknown
  always_comb begin
    mn_s  = MNEMONIC_BITS'("unknown");
    fmt_s = FMT_NONE;
    case (opcode_s)
      LOAD: begin
        fmt_s = FMT_I;
        case (funct3_s)
          F3_B:    mn_s = MNEMONIC_BITS'("lb");
          F3_H:    mn_s = MNEMONIC_BITS'("lh");
          F3_W:    mn_s = MNEMONIC_BITS'("lw");
          F3_D:    mn_s = MNEMONIC_BITS'("ld");
          F3_BU:   mn_s = MNEMONIC_BITS'("lbu");
          F3_HU:   mn_s = MNEMONIC_BITS'("lhu");
          F3_WU:   mn_s = MNEMONIC_BITS'("lwu");
          default: fmt_s = FMT_NONE;
        endcase
      end
      OP_IMM: begin
        fmt_s = FMT_I;
        case (funct3_s)
          F3_ADD:  mn_s = MNEMONIC_BITS'("addi");
          F3_SLT:  mn_s = MNEMONIC_BITS'("slti");
          F3_SLTU: mn_s = MNEMONIC_BITS'("sltiu");
          F3_XOR:  mn_s = MNEMONIC_BITS'("xori");
          F3_OR:   mn_s = MNEMONIC_BITS'("ori");
          F3_AND:  mn_s = MNEMONIC_BITS'("andi");
          F3_SLL: begin
            if (funct6_s == F6_BASE) mn_s = MNEMONIC_BITS'("slli");
            else                     fmt_s = FMT_NONE;
          end
          F3_SR: begin
            if (funct6_s == F6_BASE)     mn_s = MNEMONIC_BITS'("srli");
            else if (funct6_s == F6_ALT) mn_s = MNEMONIC_BITS'("srai");
            else                         fmt_s = FMT_NONE;
          end
          default: fmt_s = FMT_NONE;
        endcase
      end
      OP_IMM_32: begin
        fmt_s = FMT_I;
        case (funct3_s)
          F3_ADD: mn_s = MNEMONIC_BITS'("addiw");
          F3_SLL: begin
            if (funct7_s == F7_BASE) mn_s = MNEMONIC_BITS'("slliw");
            else                     fmt_s = FMT_NONE;
          end
          F3_SR: begin
            if (funct7_s == F7_BASE)     mn_s = MNEMONIC_BITS'("srliw");
            else if (funct7_s == F7_ALT) mn_s = MNEMONIC_BITS'("sraiw");
            else                         fmt_s = FMT_NONE;
          end
          default: fmt_s = FMT_NONE;
        endcase
      end
      OP: begin
        fmt_s = FMT_R;
        case ({funct7_s, funct3_s})
          {F7_BASE, F3_ADD}:  mn_s = MNEMONIC_BITS'("add");
          {F7_ALT,  F3_ADD}:  mn_s = MNEMONIC_BITS'("sub");
          {F7_BASE, F3_SLL}:  mn_s = MNEMONIC_BITS'("sll");
          {F7_BASE, F3_SLT}:  mn_s = MNEMONIC_BITS'("slt");
          {F7_BASE, F3_SLTU}: mn_s = MNEMONIC_BITS'("sltu");
          {F7_BASE, F3_XOR}:  mn_s = MNEMONIC_BITS'("xor");
          {F7_BASE, F3_SR}:   mn_s = MNEMONIC_BITS'("srl");
          {F7_ALT,  F3_SR}:   mn_s = MNEMONIC_BITS'("sra");
          {F7_BASE, F3_OR}:   mn_s = MNEMONIC_BITS'("or");
          {F7_BASE, F3_AND}:  mn_s = MNEMONIC_BITS'("and");
          default:            fmt_s = FMT_NONE;
        endcase
      end
      OP_32: begin
        fmt_s = FMT_R;
        case ({funct7_s, funct3_s})
          {F7_BASE, F3_ADD}: mn_s = MNEMONIC_BITS'("addw");
          {F7_ALT,  F3_ADD}: mn_s = MNEMONIC_BITS'("subw");
          {F7_BASE, F3_SLL}: mn_s = MNEMONIC_BITS'("sllw");
          {F7_BASE, F3_SR}:  mn_s = MNEMONIC_BITS'("srlw");
          {F7_ALT,  F3_SR}:  mn_s = MNEMONIC_BITS'("sraw");
          default:           fmt_s = FMT_NONE;
        endcase
      end
      STORE: begin
        fmt_s = FMT_S;
        case (funct3_s)
          F3_B:    mn_s = MNEMONIC_BITS'("sb");
          F3_H:    mn_s = MNEMONIC_BITS'("sh");
          F3_W:    mn_s = MNEMONIC_BITS'("sw");
          F3_D:    mn_s = MNEMONIC_BITS'("sd");
          default: fmt_s = FMT_NONE;
        endcase
      end
      BRANCH: begin
        fmt_s = FMT_B;
        case (funct3_s)
          F3_BEQ:  mn_s = MNEMONIC_BITS'("beq");
          F3_BNE:  mn_s = MNEMONIC_BITS'("bne");
          F3_BLT:  mn_s = MNEMONIC_BITS'("blt");
          F3_BGE:  mn_s = MNEMONIC_BITS'("bge");
          F3_BLTU: mn_s = MNEMONIC_BITS'("bltu");
          F3_BGEU: mn_s = MNEMONIC_BITS'("bgeu");
          default: fmt_s = FMT_NONE;
        endcase
      end
      LUI: begin
        fmt_s = FMT_U;
        mn_s  = MNEMONIC_BITS'("lui");
      end
      AUIPC: begin
        fmt_s = FMT_U;
        mn_s  = MNEMONIC_BITS'("auipc");
      end
      JAL: begin
        fmt_s = FMT_J;
        mn_s  = MNEMONIC_BITS'("jal");
      end
      JALR: begin
        if (funct3_s == 3'b000) begin
          fmt_s = FMT_I;
          mn_s  = MNEMONIC_BITS'("jalr");
        end else begin
          fmt_s = FMT_NONE;
        end
      end
      SYSTEM: begin
        if (instr_s[31:7] == 25'h0000000) begin
          fmt_s = FMT_I;
          mn_s  = MNEMONIC_BITS'("ecall");
        end else if (instr_s[31:7] == 25'h0002000) begin
          fmt_s = FMT_I;
          mn_s  = MNEMONIC_BITS'("ebreak");
        end else begin
          fmt_s = FMT_NONE;
        end
      end
      MISC_MEM: begin
        if (funct3_s == 3'b000) begin
          fmt_s = FMT_I;
          mn_s  = MNEMONIC_BITS'("fence");
        end else begin
          fmt_s = FMT_NONE;
        end
      end
      default: fmt_s = FMT_NONE;
    endcase
  end

  assign bus.nstage2_op        = OP_W'(mn_s);
  assign bus.nstage2_immediate = imm_gen(fmt_s, instr_s);
  assign bus.nstage2_dest      = has_rd(fmt_s) ? instr_s[11:7] : 5'd0;
  assign bus.nstage2_pc        = bus.stage1_pc;

  decode_regfile #(
    .WIDTH (REGISTER_WIDTH)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .rs1     (instr_s[19:15]),
    .rs2     (instr_s[24:20]),
    .wr_en   (bus.wr_en),
    .wr_idx  (bus.stage3_dest_reg[4:0]),
    .wr_data (bus.stage3_alu_result),
    .display (bus.display_regs),
    .rd1     (bus.nstage2_valA),
    .rd2     (bus.nstage2_valB)
  );

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: register-file sequences plus a table of
// hand-encoded RV64I instructions with hand-computed results.
module tb_decode;

  logic clk;
  logic reset;

  decode_if #(
    .REGISTER_WIDTH         (64),
    .REGISTER_NUMBER_WIDTH  (5),
    .INSTRUCTION_NAME_WIDTH (12)
  ) bus ();

  decode #(
    .REGISTER_WIDTH         (64),
    .REGISTER_NUMBER_WIDTH  (5),
    .INSTRUCTION_NAME_WIDTH (12)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [96:0] op;
    logic [4:0]  dest;
    logic [63:0] imm;
    logic [63:0] a;
    logic [63:0] b;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [63:0] X1V = 64'h0000_0000_0000_ABCD;
  localparam logic [63:0] X2V = 64'h8000_0000_0000_0001;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [96:0] mn(input string s);
    logic [96:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) begin
      r = {r[88:0], s[i]};
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [96:0] op, input logic [4:0] dest,
                           input logic [63:0] imm, input logic [63:0] a, input logic [63:0] b);
    check({name, ".op"},   128'(bus.nstage2_op),        128'(op));
    check({name, ".dest"}, 128'(bus.nstage2_dest),      128'(dest));
    check({name, ".imm"},  128'(bus.nstage2_immediate), 128'(imm));
    check({name, ".valA"}, 128'(bus.nstage2_valA),      128'(a));
    check({name, ".valB"}, 128'(bus.nstage2_valB),      128'(b));
  endtask

  task automatic add(input logic [31:0] instr, input string op, input logic [4:0] dest,
                     input logic [63:0] imm, input logic [63:0] a, input logic [63:0] b);
    vec_t v;
    v.instr = instr; v.op = mn(op); v.dest = dest; v.imm = imm; v.a = a; v.b = b;
    vecs.push_back(v);
  endtask

  task automatic apply_instr(input logic [31:0] instr);
    @(negedge clk);
    bus.stage1_instruction_bits = instr;
    bus.stage1_pc = {instr, ~instr};
    #1;
  endtask

  task automatic write_reg(input logic [5:0] idx, input logic [63:0] data);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.stage3_dest_reg = idx;
    bus.stage3_alu_result = data;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.stage1_instruction_bits = 32'h0;
    bus.stage1_pc = 64'h0;
    bus.stage3_dest_reg = 6'd0;
    bus.stage3_alu_result = 64'h0;
    bus.wr_en = 1'b0;
    bus.display_regs = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Post-reset decode of addi x1, x0, 5
    apply_instr(32'h00500093);
    check_out("reset_addi", mn("addi"), 5'd1, 64'd5, 64'd0, 64'd0);
    check("reset_pc", 128'(bus.nstage2_pc), 128'({32'h00500093, 32'hFFAFFF6C}));

    // Write x1 then read it on both ports
    write_reg(6'd1, 64'h1234);
    apply_instr(32'h00108133);
    check_out("add_x1", mn("add"), 5'd2, 64'd0, 64'h1234, 64'h1234);

    // Writes to x0 are discarded
    write_reg(6'd0, 64'hFFFF);
    apply_instr(32'h00000033);
    check_out("x0_write", mn("add"), 5'd0, 64'd0, 64'd0, 64'd0);

    // Same-cycle bypass before the clock, then the stored value after it
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.stage3_dest_reg = 6'd1;
    bus.stage3_alu_result = X1V;
    bus.stage1_instruction_bits = 32'h00108133;
    #1;
    check("bypass_a", 128'(bus.nstage2_valA), 128'(X1V));
    check("bypass_b", 128'(bus.nstage2_valB), 128'(X1V));
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    #1;
    check("stored_x1", 128'(bus.nstage2_valA), 128'(X1V));

    // No bypass onto x0
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.stage3_dest_reg = 6'd0;
    bus.stage3_alu_result = 64'h99;
    bus.stage1_instruction_bits = 32'h00000033;
    #1;
    check("bypass_x0", 128'(bus.nstage2_valA), 128'(64'd0));
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;

    write_reg(6'd2, X2V);

    add(32'hFFF00093, "addi",    5'd1, ONES,                    64'd0, 64'd0);
    add(32'hFE000EE3, "beq",     5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0);
    add(32'h123452B7, "lui",     5'd5, 64'h0000_0000_1234_5000, 64'd0, 64'd0);
    add(32'h00000000, "unknown", 5'd0, 64'd0,                   64'd0, 64'd0);
    add(32'h00113423, "sd",      5'd0, 64'd8,                   X2V,   X1V);
    add(32'hFE112E23, "sw",      5'd0, 64'hFFFF_FFFF_FFFF_FFFC, X2V,   X1V);
    add(32'h001000EF, "jal",     5'd1, 64'h800,                 64'd0, X1V);
    add(32'hFFFFF0EF, "jal",     5'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'd0);
    add(32'h80000197, "auipc",   5'd3, 64'hFFFF_FFFF_8000_0000, 64'd0, 64'd0);
    add(32'h4030D21B, "sraiw",   5'd4, 64'h403,                 X1V,   64'd0);
    add(32'h43F0D213, "srai",    5'd4, 64'h43F,                 X1V,   64'd0);
    add(32'h402082B3, "sub",     5'd5, 64'd0,                   X1V,   X2V);
    add(32'h402082BB, "subw",    5'd5, 64'd0,                   X1V,   X2V);
    add(32'hFF813303, "ld",      5'd6, 64'hFFFF_FFFF_FFFF_FFF8, X2V,   64'd0);
    add(32'h0000E383, "lwu",     5'd7, 64'd0,                   X1V,   64'd0);
    add(32'h0020F863, "bgeu",    5'd0, 64'd16,                  X1V,   X2V);
    add(32'h00008067, "jalr",    5'd0, 64'd0,                   X1V,   64'd0);
    add(32'h00000073, "ecall",   5'd0, 64'd0,                   64'd0, 64'd0);
    add(32'h00100073, "ebreak",  5'd0, 64'd1,                   64'd0, X1V);
    add(32'h0FF0000F, "fence",   5'd0, 64'h0FF,                 64'd0, 64'd0);
    add(32'h02000033, "unknown", 5'd0, 64'd0,                   64'd0, 64'd0);
    add(32'h80001013, "unknown", 5'd0, 64'd0,                   64'd0, 64'd0);
    add(32'h00002063, "unknown", 5'd0, 64'd0,                   64'd0, 64'd0);
    add(32'h02009093, "slli",    5'd1, 64'd32,                  X1V,   64'd0);
    add(32'hFFF0B113, "sltiu",   5'd2, ONES,                    X1V,   64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_instr(vecs[i].instr);
      check_out($sformatf("vec%0d", i), vecs[i].op, vecs[i].dest, vecs[i].imm,
                vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d.pc", i), 128'(bus.nstage2_pc),
            128'({vecs[i].instr, ~vecs[i].instr}));
    end

    // Reset wins over a simultaneous write
    write_reg(6'd3, 64'd7);
    apply_instr(32'h00318033);
    check("x3_written", 128'(bus.nstage2_valA), 128'(64'd7));
    @(negedge clk);
    reset = 1'b1;
    bus.wr_en = 1'b1;
    bus.stage3_dest_reg = 6'd3;
    bus.stage3_alu_result = 64'h55;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.wr_en = 1'b0;
    apply_instr(32'h00318033);
    check("x3_after_reset", 128'(bus.nstage2_valA), 128'(64'd0));
    apply_instr(32'h00108133);
    check("x1_after_reset", 128'(bus.nstage2_valA), 128'(64'd0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
